// File: rtl/sid_pkg.sv
// Shared definitions for the SID filter/mixer: resonance table, FSM and
// MAC step encodings, and a generic saturation helper.
package sid_pkg;

    // Widest intermediate value any caller may hand to sat()
    localparam int SAT_W = 64;

    // Resonance register to damping factor q, unsigned Q1.10
    localparam logic [10:0] RES_LUT [16] = '{
        11'h5a8, 11'h52b, 11'h4c2, 11'h468, 11'h41b, 11'h3d8, 11'h39d, 11'h368,
        11'h339, 11'h30f, 11'h2e9, 11'h2c6, 11'h2a7, 11'h28a, 11'h270, 11'h257
    };

    typedef enum logic [2:0] {
        ST_IDLE, ST_ACC, ST_HP, ST_BP, ST_LP, ST_MIX, ST_VOL, ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        STEP_NONE, STEP_HP, STEP_BP, STEP_LP, STEP_VOL
    } step_t;

    // Clamp a signed value into the range of a signed 'width'-bit number
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] value,
                                                    input int width);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/sid_svf_mac.sv
// Shared multiply / arithmetic-shift / saturating-add unit. One operation per
// cycle selected by 'step'; owns the hp/bp/lp filter state registers.
module sid_svf_mac
    import sid_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  step_t                   step,
    input  logic signed [ACC_W-1:0] fin,
    input  logic signed [ACC_W-1:0] mix,
    input  logic        [16:0]      w0,
    input  logic        [10:0]      q,
    input  logic        [3:0]       vol,
    output logic signed [ACC_W-1:0] hp,
    output logic signed [ACC_W-1:0] bp,
    output logic signed [ACC_W-1:0] lp,
    output logic signed [OUT_W-1:0] vol_out
);

    localparam int PROD_W = ACC_W + 18;
    localparam int SUM_W  = PROD_W + 2;

    logic signed [17:0]       mul_a;
    logic signed [ACC_W-1:0]  mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;
    logic signed [ACC_W-1:0]  acc_sat;

    // Operand select, full-width product, shift and add for the active step
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step)
            STEP_HP:  begin mul_a = signed'({7'd0, q});   mul_b = bp;  end
            STEP_BP:  begin mul_a = signed'({1'b0, w0});  mul_b = hp;  end
            STEP_LP:  begin mul_a = signed'({1'b0, w0});  mul_b = bp;  end
            STEP_VOL: begin mul_a = signed'({14'd0, vol}); mul_b = mix; end
            default:  ;
        endcase
        prod = PROD_W'(mul_a) * PROD_W'(mul_b);
        sum  = '0;
        case (step)
            STEP_HP:  sum = SUM_W'(fin) - SUM_W'(lp) - SUM_W'(prod >>> 10);
            STEP_BP:  sum = SUM_W'(bp) + SUM_W'(prod >>> 20);
            STEP_LP:  sum = SUM_W'(lp) + SUM_W'(prod >>> 20);
            STEP_VOL: sum = SUM_W'(prod >>> 4);
            default:  ;
        endcase
        acc_sat = ACC_W'(sat(SAT_W'(sum), ACC_W));
        vol_out = OUT_W'(sat(SAT_W'(sum), OUT_W));
    end

    // Filter state update; each step writes exactly one state register
    always_ff @(posedge clk) begin
        if (rst) begin
            hp <= '0;
            bp <= '0;
            lp <= '0;
        end else begin
            case (step)
                STEP_HP: hp <= acc_sat;
                STEP_BP: bp <= acc_sat;
                STEP_LP: lp <= acc_sat;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sid_filter_mix.sv
// SID state-variable filter and output mixer: sequences voice accumulation,
// the HP/BP/LP filter update, mixing and master volume per sample tick.
module sid_filter_mix
    import sid_pkg::*;
#(
    parameter int NVOICES = 3,
    parameter int SW      = 12,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [NVOICES*SW-1:0]   voice_in,
    input  logic [10:0]             reg_fc,
    input  logic [3:0]              reg_res,
    input  logic [NVOICES-1:0]      filt_en,
    input  logic [3:0]              mode,
    input  logic [3:0]              vol,
    output logic signed [OUT_W-1:0] sample_out,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int KW    = $clog2(NVOICES);
    localparam int MIX_W = ACC_W + 2;

    state_t state, state_nxt;
    step_t  step;
    logic   accept;
    logic   last_k;

    logic [NVOICES*SW-1:0] voice_sh;
    logic [10:0]           fc_sh;
    logic [3:0]            res_sh;
    logic [NVOICES-1:0]    filt_sh;
    logic [3:0]            mode_sh;
    logic [3:0]            vol_sh;

    logic [KW-1:0]           k;
    logic [SW-1:0]           voice_arr [NVOICES];
    logic signed [ACC_W-1:0] voice_s;
    logic signed [ACC_W-1:0] fin, direct, mix_q;
    logic signed [MIX_W-1:0] mix_full;
    logic signed [ACC_W-1:0] hp, bp, lp;
    logic signed [OUT_W-1:0] vol_out;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencing: next state, MAC step and status outputs
    always_comb begin
        state_nxt    = state;
        step         = STEP_NONE;
        accept       = 1'b0;
        busy         = 1'b0;
        sample_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    accept    = 1'b1;
                    state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                busy = 1'b1;
                if (last_k) state_nxt = ST_HP;
            end
            ST_HP:  begin busy = 1'b1; step = STEP_HP;  state_nxt = ST_BP;  end
            ST_BP:  begin busy = 1'b1; step = STEP_BP;  state_nxt = ST_LP;  end
            ST_LP:  begin busy = 1'b1; step = STEP_LP;  state_nxt = ST_MIX; end
            ST_MIX: begin busy = 1'b1;                  state_nxt = ST_VOL; end
            ST_VOL: begin busy = 1'b1; step = STEP_VOL; state_nxt = ST_DONE; end
            ST_DONE: begin
                sample_valid = 1'b1;
                if (tick) begin
                    accept    = 1'b1;
                    state_nxt = ST_ACC;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        overrun = tick & busy;
    end

    // Current voice: offset-binary to two's complement is an MSB flip
    always_comb begin
        for (int i = 0; i < NVOICES; i++) begin
            voice_arr[i] = voice_sh[i*SW +: SW];
        end
        voice_s = ACC_W'(signed'({~voice_arr[k][SW-1], voice_arr[k][SW-2:0]}));
        last_k  = (k == KW'(NVOICES - 1));
    end

    // Direct plus enabled filter outputs, with two guard bits
    always_comb begin
        mix_full = MIX_W'(direct);
        if (mode_sh[2]) mix_full = mix_full + MIX_W'(hp);
        if (mode_sh[1]) mix_full = mix_full + MIX_W'(bp);
        if (mode_sh[0]) mix_full = mix_full + MIX_W'(lp);
    end

    // Shadow capture, voice accumulation, mix register and output register.
    // The mix is clamped to ACC_W before volume: anything that large already
    // saturates the output for any nonzero volume, so the result is unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            fin        <= '0;
            direct     <= '0;
            k          <= '0;
            mix_q      <= '0;
            sample_out <= '0;
        end else begin
            if (accept) begin
                voice_sh <= voice_in;
                fc_sh    <= reg_fc;
                res_sh   <= reg_res;
                filt_sh  <= filt_en;
                mode_sh  <= mode;
                vol_sh   <= vol;
                fin      <= '0;
                direct   <= '0;
                k        <= '0;
            end
            if (state == ST_ACC) begin
                if (filt_sh[k]) begin
                    fin <= fin + voice_s;
                end else if (!(mode_sh[3] && last_k)) begin
                    direct <= direct + voice_s;
                end
                k <= k + KW'(1);
            end
            if (state == ST_MIX) begin
                mix_q <= ACC_W'(sat(SAT_W'(mix_full), ACC_W));
            end
            if (state == ST_VOL) begin
                sample_out <= vol_out;
            end
        end
    end

    sid_svf_mac #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .step    (step),
        .fin     (fin),
        .mix     (mix_q),
        .w0      ({fc_sh, 6'b0}),
        .q       (RES_LUT[res_sh]),
        .vol     (vol_sh),
        .hp      (hp),
        .bp      (bp),
        .lp      (lp),
        .vol_out (vol_out)
    );

endmodule

// File: tb/tb_sid_filter_mix.sv
// Cycle-level bench for sid_filter_mix: directed and random ticks, checked
// every cycle against a behavioural model of the filter/mixer arithmetic.
module tb_sid_filter_mix;

    localparam int N     = 3;
    localparam int SW    = 12;
    localparam int VW    = N * SW;
    localparam int ACC_W = 32;
    localparam int OUT_W = 16;

    localparam logic [10:0] LUT [16] = '{
        11'h5a8, 11'h52b, 11'h4c2, 11'h468, 11'h41b, 11'h3d8, 11'h39d, 11'h368,
        11'h339, 11'h30f, 11'h2e9, 11'h2c6, 11'h2a7, 11'h28a, 11'h270, 11'h257
    };

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    tick;
    logic [VW-1:0]           voice_in;
    logic [10:0]             reg_fc;
    logic [3:0]              reg_res;
    logic [N-1:0]            filt_en;
    logic [3:0]              mode;
    logic [3:0]              vol;
    logic signed [OUT_W-1:0] sample_out;
    logic                    sample_valid;
    logic                    busy;
    logic                    overrun;

    int     checks = 0;
    int     errors = 0;
    int     cyc;
    int     last_acc;
    bit     have_acc;
    longint hp_m, bp_m, lp_m;
    longint exp_sample, last_sample;

    always #5 clk = ~clk;

    sid_filter_mix #(
        .NVOICES (N),
        .SW      (SW),
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .voice_in     (voice_in),
        .reg_fc       (reg_fc),
        .reg_res      (reg_res),
        .filt_en      (filt_en),
        .mode         (mode),
        .vol          (vol),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    function automatic longint clampTo(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // One sample of the filter/mixer, using the current inputs and model state
    function automatic longint modelSample();
        longint fin_v, direct_v, v, w0, q, filt, mix;
        fin_v    = 0;
        direct_v = 0;
        for (int i = 0; i < N; i++) begin
            v = longint'(voice_in[i*SW +: SW]) - 2048;
            if (filt_en[i]) fin_v += v;
            else if (!(mode[3] && i == N - 1)) direct_v += v;
        end
        w0   = longint'(reg_fc) * 64;
        q    = longint'(LUT[reg_res]);
        hp_m = clampTo(fin_v - lp_m - ((q * bp_m) >>> 10), ACC_W);
        bp_m = clampTo(bp_m + ((w0 * hp_m) >>> 20), ACC_W);
        lp_m = clampTo(lp_m + ((w0 * bp_m) >>> 20), ACC_W);
        filt = (mode[2] ? hp_m : 0) + (mode[1] ? bp_m : 0) + (mode[0] ? lp_m : 0);
        mix  = direct_v + filt;
        return clampTo((mix * longint'(vol)) >>> 4, OUT_W);
    endfunction

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [VW-1:0] v, input logic [N-1:0] fe,
                                 input logic [3:0] md, input logic [10:0] fc,
                                 input logic [3:0] rs, input logic [3:0] vl);
        voice_in = v;
        filt_en  = fe;
        mode     = md;
        reg_fc   = fc;
        reg_res  = rs;
        vol      = vl;
    endtask

    task automatic randomizeInputs();
        voice_in = VW'({$urandom(), $urandom()});
        filt_en  = N'($urandom());
        mode     = 4'($urandom());
        reg_fc   = 11'($urandom());
        reg_res  = 4'($urandom());
        vol      = 4'($urandom());
    endtask

    // One clock cycle: drive tick/rst at the falling edge, check every output
    task automatic stepCycle(input bit do_tick, input bit do_rst);
        int   rel;
        logic exp_busy;
        logic exp_valid;
        tick = do_tick;
        rst  = do_rst;
        #1;
        rel       = cyc - last_acc;
        exp_busy  = have_acc && rel >= 1 && rel <= N + 5;
        exp_valid = have_acc && rel == N + 6;
        checkOutput("busy", busy, exp_busy);
        checkOutput("overrun", overrun, do_tick && exp_busy);
        checkOutput("sample_valid", sample_valid, exp_valid);
        if (exp_valid) begin
            checkOutput("sample_out", sample_out, exp_sample);
            last_sample = exp_sample;
        end else begin
            checkOutput("sample_hold", sample_out, last_sample);
        end
        if (do_rst) begin
            have_acc    = 1'b0;
            hp_m        = 0;
            bp_m        = 0;
            lp_m        = 0;
            last_sample = 0;
        end else if (do_tick && !exp_busy) begin
            last_acc   = cyc;
            have_acc   = 1'b1;
            exp_sample = modelSample();
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic runSeq(input int idle);
        stepCycle(1'b1, 1'b0);
        repeat (idle) stepCycle(1'b0, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        tick        = 1'b0;
        cyc         = 0;
        last_acc    = 0;
        have_acc    = 1'b0;
        hp_m        = 0;
        bp_m        = 0;
        lp_m        = 0;
        exp_sample  = 0;
        last_sample = 0;
        applyStimulus({3{12'h800}}, 3'b000, 4'h0, 11'h000, 4'h0, 4'h0);
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        stepCycle(1'b0, 1'b1);
        stepCycle(1'b0, 1'b0);

        $display("[TB] direct path cases");
        applyStimulus({3{12'h800}}, 3'b000, 4'h0, 11'h000, 4'h0, 4'hF);
        runSeq(9);
        checkOutput("silence", sample_out, 0);
        applyStimulus({12'h800, 12'h800, 12'hFFF}, 3'b000, 4'h0, 11'h000, 4'h0, 4'hF);
        runSeq(9);
        checkOutput("voice0_full", sample_out, 1919);
        applyStimulus({12'hFFF, 12'h800, 12'h800}, 3'b000, 4'h8, 11'h000, 4'h0, 4'hF);
        runSeq(9);
        checkOutput("last_off", sample_out, 0);
        applyStimulus({12'hFFF, 12'h800, 12'h800}, 3'b000, 4'h0, 11'h000, 4'h0, 4'hF);
        runSeq(9);
        checkOutput("voice2_direct", sample_out, 1919);
        applyStimulus({12'h800, 12'h800, 12'hFFF}, 3'b000, 4'h0, 11'h000, 4'h0, 4'h0);
        runSeq(9);
        checkOutput("vol_zero", sample_out, 0);

        $display("[TB] lowpass step, back-to-back ticks");
        applyStimulus({12'hFFF, 12'h800, 12'h800}, 3'b100, 4'h9, 11'h7FF, 4'h0, 4'hF);
        repeat (30) runSeq(8);
        stepCycle(1'b0, 1'b0);

        $display("[TB] resonance sweep");
        stepCycle(1'b0, 1'b1);
        stepCycle(1'b0, 1'b0);
        applyStimulus({12'h800, 12'h800, 12'hFFF}, 3'b001, 4'h2, 11'h400, 4'hF, 4'hF);
        repeat (200) runSeq(8);
        stepCycle(1'b0, 1'b0);

        $display("[TB] ticks every 4 cycles");
        for (int c = 0; c < 40; c++) begin
            randomizeInputs();
            stepCycle((c % 4) == 0, 1'b0);
        end
        repeat (10) stepCycle(1'b0, 1'b0);

        $display("[TB] reset mid-sequence");
        applyStimulus({12'h123, 12'hABC, 12'hFFF}, 3'b011, 4'h7, 11'h3FF, 4'h5, 4'hF);
        stepCycle(1'b1, 1'b0);
        repeat (4) stepCycle(1'b0, 1'b0);
        stepCycle(1'b0, 1'b1);
        stepCycle(1'b0, 1'b0);
        applyStimulus({12'h800, 12'h800, 12'hFFF}, 3'b001, 4'h1, 11'h7FF, 4'h3, 4'hF);
        runSeq(9);

        $display("[TB] random sequences with mid-sequence input changes");
        for (int s = 0; s < 60; s++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            randomizeInputs();
            stepCycle(1'b1, 1'b0);
            for (int j = 0; j < 8 + gap; j++) begin
                randomizeInputs();
                stepCycle(1'b0, 1'b0);
            end
        end
        repeat (3) stepCycle(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
